tx: RTL and testbench



---
 rtl/tx.sv | 188 ++++++++++++++++++
 tb/tb_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tx.sv
// tx: UART transmitter. Serializes one 5..8-bit character per send request
// as start bit, LSB-first data, optional even/odd parity and one stop bit,
// at one of four bit periods derived from DIV_38400. The line idles high.
module tx #(
   parameter int unsigned DIV_38400 = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       send,
   input  logic [7:0] data,
   input  logic [3:0] data_length,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   output logic       serial_data_out
);

   // Wide enough for the slowest bit period minus one (8 x DIV_38400 - 1).
   localparam int unsigned CNT_W = $clog2(DIV_38400 * 8);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       data_q, data_d;
   logic [3:0]       len_q, len_d;
   logic [1:0]       par_q, par_d;
   logic [1:0]       baud_q, baud_d;
   logic             out_q, out_d;
   logic             take;
   logic [3:0]       len_in;

   // Reload value of the bit-period down-counter. Unknown or unexpected
   // selects fall to the fastest rate instead of propagating garbage.
   function automatic logic [CNT_W-1:0] reload(input logic [1:0] br);
      case (br)
         2'd0:    return CNT_W'(DIV_38400 * 8 - 1);
         2'd1:    return CNT_W'(DIV_38400 * 4 - 1);
         2'd2:    return CNT_W'(DIV_38400 * 2 - 1);
         default: return CNT_W'(DIV_38400 - 1);
      endcase
   endfunction

   // Lengths outside 5..8 saturate to the nearest supported length.
   function automatic logic [3:0] clamp_len(input logic [3:0] l);
      if (l < 4'd5)      return 4'd5;
      else if (l > 4'd8) return 4'd8;
      else               return l;
   endfunction

   // Bits above the frame length are zeroed at latch time so they can
   // never reach the parity calculation.
   function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [3:0] l);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[i] = d[i] & (4'(i) < l);
      end
      return m;
   endfunction

   assign len_in = clamp_len(data_length);

   // A frame is taken in IDLE, or on the last stop-bit cycle so that a held
   // send produces back-to-back frames with no idle gap.
   assign take = send && ((state_q == IDLE) || ((state_q == STOP) && (cyc_q == '0)));

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every signal driven here gets a default first; a missing
      // assignment on any path would infer a latch.
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      data_d  = data_q;
      len_d   = len_q;
      par_d   = par_q;
      baud_d  = baud_q;
      out_d   = out_q;

      case (state_q)
         IDLE: begin
            out_d = 1'b1;
         end

         START: begin
            if (cyc_q == '0) begin
               state_d = DATA;
               out_d   = data_q[0];
               bit_d   = '0;
               cyc_d   = reload(baud_q);
            end else begin
               cyc_d = cyc_q - CNT_W'(1);
            end
         end

         DATA: begin
            if (cyc_q == '0) begin
               cyc_d = reload(baud_q);
               if ({1'b0, bit_q} == len_q - 4'd1) begin
                  if (!par_q[1]) begin
                     state_d = PARITY;
                     out_d   = (^data_q) ^ par_q[0];
                  end else begin
                     state_d = STOP;
                     out_d   = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  out_d = data_q[bit_q + 3'd1];
               end
            end else begin
               cyc_d = cyc_q - CNT_W'(1);
            end
         end

         PARITY: begin
            if (cyc_q == '0) begin
               state_d = STOP;
               out_d   = 1'b1;
               cyc_d   = reload(baud_q);
            end else begin
               cyc_d = cyc_q - CNT_W'(1);
            end
         end

         STOP: begin
            if (cyc_q == '0) begin
               state_d = IDLE;
               out_d   = 1'b1;
            end else begin
               cyc_d = cyc_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            out_d   = 1'b1;
         end
      endcase

      // Starting a frame overrides whatever the case above decided.
      if (take) begin
         state_d = START;
         out_d   = 1'b0;
         bit_d   = '0;
         cyc_d   = reload(baud_rate);
         data_d  = mask_data(data, len_in);
         len_d   = len_in;
         par_d   = parity_type;
         baud_d  = baud_rate;
      end
   end

   // State, counters, latched frame fields and the registered line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         len_q   <= '0;
         par_q   <= '0;
         baud_q  <= '0;
         out_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         len_q   <= len_d;
         par_q   <= par_d;
         baud_q  <= baud_d;
         out_q   <= out_d;
      end
   end

   assign serial_data_out = out_q;

endmodule

// File: tb/tb_tx.sv
// tb_tx: frame-level checks of the UART transmitter. Expected line levels
// are queued per bit when a frame is requested and compared on every cycle
// of each bit as the line is observed.
module tb_tx;

   localparam int unsigned DIV = 4;

   logic       clk;
   logic       resetn;
   logic       send;
   logic [7:0] data;
   logic [3:0] data_length;
   logic [1:0] parity_type;
   logic [1:0] baud_rate;
   logic       serial_data_out;

   tx #(.DIV_38400(DIV)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .send           (send),
      .data           (data),
      .data_length    (data_length),
      .parity_type    (parity_type),
      .baud_rate      (baud_rate),
      .serial_data_out(serial_data_out)
   );

   typedef struct {
      logic [7:0] data;
      logic [3:0] data_length;
      logic [1:0] parity_type;
      logic [1:0] baud_rate;
      int         exp_len;
      bit         exp_par_en;
      logic       exp_par;
      int         exp_period;
   } vec_t;

   typedef struct {
      logic val;
      int   per;
   } bit_t;

   vec_t vecs[17];
   bit_t exp_q[$];
   int   n_vec;
   int   n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Queue the expected line levels of one frame, bit by bit.
   task automatic push_frame(input vec_t v);
      exp_q.push_back('{1'b0, v.exp_period});
      for (int i = 0; i < v.exp_len; i++) exp_q.push_back('{v.data[i], v.exp_period});
      if (v.exp_par_en) exp_q.push_back('{v.exp_par, v.exp_period});
      exp_q.push_back('{1'b1, v.exp_period});
   endtask

   // Drive a request so that it is sampled at the next rising edge; returns
   // 1 ns after that edge. send stays high only when hold is set.
   task automatic apply(input vec_t v, input bit hold);
      @(negedge clk);
      data        = v.data;
      data_length = v.data_length;
      parity_type = v.parity_type;
      baud_rate   = v.baud_rate;
      send        = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) send = 1'b0;
   endtask

   // Drain the scoreboard: every cycle of every expected bit is compared.
   task automatic run_bits(input string tag);
      bit_t e;
      int   b;
      b = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int c = 0; c < e.per; c++) begin
            check($sformatf("%s bit%0d cyc%0d", tag, b, c), serial_data_out, e.val);
            @(posedge clk);
            #1;
         end
         b++;
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         check($sformatf("%s idle cyc%0d", tag, c), serial_data_out, 1'b1);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t rv;
      n_vec = 0;
      n_err = 0;

      //          data   len    par   baud  len par_en par  period
      vecs[0]  = '{8'h81, 4'd8,  2'd0, 2'd3, 8, 1'b1, 1'b0, DIV};
      vecs[1]  = '{8'h83, 4'd8,  2'd0, 2'd3, 8, 1'b1, 1'b1, DIV};
      vecs[2]  = '{8'h81, 4'd8,  2'd1, 2'd3, 8, 1'b1, 1'b1, DIV};
      vecs[3]  = '{8'h83, 4'd8,  2'd1, 2'd3, 8, 1'b1, 1'b0, DIV};
      vecs[4]  = '{8'h01, 4'd8,  2'd2, 2'd3, 8, 1'b0, 1'b0, DIV};
      vecs[5]  = '{8'h03, 4'd8,  2'd3, 2'd3, 8, 1'b0, 1'b0, DIV};
      vecs[6]  = '{8'h00, 4'd5,  2'd2, 2'd3, 5, 1'b0, 1'b0, DIV};
      vecs[7]  = '{8'h00, 4'd6,  2'd2, 2'd3, 6, 1'b0, 1'b0, DIV};
      vecs[8]  = '{8'h00, 4'd7,  2'd2, 2'd3, 7, 1'b0, 1'b0, DIV};
      vecs[9]  = '{8'h00, 4'd8,  2'd2, 2'd3, 8, 1'b0, 1'b0, DIV};
      vecs[10] = '{8'hE7, 4'd3,  2'd0, 2'd3, 5, 1'b1, 1'b1, DIV};
      vecs[11] = '{8'hA5, 4'd12, 2'd1, 2'd3, 8, 1'b1, 1'b1, DIV};
      vecs[12] = '{8'hFF, 4'd7,  2'd0, 2'd3, 7, 1'b1, 1'b1, DIV};
      vecs[13] = '{8'h55, 4'd8,  2'd2, 2'd0, 8, 1'b0, 1'b0, DIV * 8};
      vecs[14] = '{8'h55, 4'd8,  2'd2, 2'd1, 8, 1'b0, 1'b0, DIV * 4};
      vecs[15] = '{8'h55, 4'd8,  2'd2, 2'd2, 8, 1'b0, 1'b0, DIV * 2};
      vecs[16] = '{8'h55, 4'd8,  2'd2, 2'd3, 8, 1'b0, 1'b0, DIV};

      resetn      = 1'b0;
      send        = 1'b0;
      data        = '0;
      data_length = 4'd8;
      parity_type = 2'd0;
      baud_rate   = 2'd3;
      repeat (3) @(posedge clk);
      #1;
      check("reset line", serial_data_out, 1'b1);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check_idle("post-reset", 4);

      // Table: parity, lengths, clamping and baud rates.
      for (int i = 0; i < 17; i++) begin
         push_frame(vecs[i]);
         apply(vecs[i], 1'b0);
         run_bits($sformatf("vec%0d", i));
         check_idle($sformatf("vec%0d", i), 3);
      end

      // Busy: inputs change and send pulses mid-frame; the frame is unchanged
      // and no second frame follows.
      push_frame(vecs[0]);
      apply(vecs[0], 1'b0);
      fork
         run_bits("busy");
         begin
            repeat (10) @(negedge clk);
            data        = 8'hFF;
            parity_type = 2'd1;
            data_length = 4'd5;
            baud_rate   = 2'd0;
            send        = 1'b1;
            @(negedge clk);
            send        = 1'b0;
         end
      join
      check_idle("busy", 2 * DIV);

      // Back-to-back: send held high, data changed during the first frame
      // takes effect only in the second.
      push_frame(vecs[0]);
      push_frame(vecs[1]);
      apply(vecs[0], 1'b1);
      fork
         run_bits("b2b");
         begin
            repeat (20) @(negedge clk);
            data = 8'h83;
            repeat (30) @(negedge clk);
            send = 1'b0;
         end
      join
      check_idle("b2b", 2 * DIV);

      // Reset two cycles into an even-parity frame, then a clean frame.
      rv = '{8'h00, 4'd8, 2'd0, 2'd3, 8, 1'b1, 1'b0, DIV};
      apply(rv, 1'b0);
      @(posedge clk);
      #3;
      check("pre-reset start bit", serial_data_out, 1'b0);
      resetn = 1'b0;
      #1;
      check("async reset line", serial_data_out, 1'b1);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check_idle("after reset", 3);
      push_frame(rv);
      apply(rv, 1'b0);
      run_bits("after reset");
      check_idle("after reset end", 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
